// File: rtl/comm_pkg.sv
// Shared definitions for the transmit-channel arbiter: FSM encoding, default byte width and
// one-hot grant codes.
package comm_pkg;

  localparam int unsigned DataWDefault = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StTxReq = 3'd1,
    StTxAck = 3'd2,
    StUpAck = 3'd3,
    StHold  = 3'd4
  } arb_state_e;

  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] Grant0    = 2'b01;
  localparam logic [1:0] Grant1    = 2'b10;

  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? Grant1 : Grant0;
  endfunction

endpackage

// File: rtl/hsk_watchdog.sv
// Saturating cycle counter with synchronous clear and count enable; flags expiry on the cycle
// in which the enabled count reaches LIMIT occupied cycles.
module hsk_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_clear,
  input  logic in_enable,
  output logic out_expire
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_clear) begin
      cnt_d = '0;
    end else if (in_enable && (cnt_q != CntW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count of LIMIT-1 means this is the LIMIT-th cycle spent in the watched state.
  assign out_expire = in_enable && (cnt_q >= CntW'(LIMIT - 1));

endmodule

// File: rtl/tx_byte_arbiter.sv
// Round-robin arbiter sharing one 4-phase byte channel between two sources, with per-frame
// locking and a watchdog against stalled transmitters or abandoned locks.
module tx_byte_arbiter
  import comm_pkg::*;
#(
  parameter int unsigned DATA_W         = DataWDefault,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [DATA_W-1:0] in_req0_data,
  input  logic              in_req0_hsk_req,
  input  logic              in_req0_lock,
  output logic              out_req0_hsk_ack,
  input  logic [DATA_W-1:0] in_req1_data,
  input  logic              in_req1_hsk_req,
  input  logic              in_req1_lock,
  output logic              out_req1_hsk_ack,
  output logic [DATA_W-1:0] out_data_tx,
  output logic              out_data_tx_hsk_req,
  input  logic              in_data_tx_hsk_ack,
  output logic [1:0]        out_grant,
  output logic              out_busy,
  output logic              out_timeout
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        grant_q, grant_d;
  logic              owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              rr_q, rr_d;
  logic              dreq_q, dreq_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;

  logic              win;
  logic              owner_req;
  logic              owner_lock;
  logic [DATA_W-1:0] owner_data;
  logic              expire;
  logic              wd_clear;
  logic              wd_enable;

  assign owner_req  = owner_q ? in_req1_hsk_req : in_req0_hsk_req;
  assign owner_lock = owner_q ? in_req1_lock : in_req0_lock;
  assign owner_data = owner_q ? in_req1_data : in_req0_data;

  assign wd_clear  = (state_d != state_q);
  assign wd_enable = (state_q == StTxReq) || (state_q == StTxAck) || (state_q == StHold);

  hsk_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_clear  (wd_clear),
    .in_enable (wd_enable),
    .out_expire(expire)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    tmo_d   = 1'b0;
    win     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_req0_hsk_req || in_req1_hsk_req) begin
          win     = (in_req0_hsk_req && in_req1_hsk_req) ? rr_q : in_req1_hsk_req;
          owner_d = win;
          data_d  = win ? in_req1_data : in_req0_data;
          lock_d  = win ? in_req1_lock : in_req0_lock;
          grant_d = grant_onehot(win);
          state_d = StTxReq;
        end
      end
      StTxReq: begin
        if (in_data_tx_hsk_ack) begin
          state_d = StTxAck;
        end else if (expire) begin
          // Byte is dropped but the source is still acked so it cannot hang.
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = StUpAck;
        end
      end
      StTxAck: begin
        if (!in_data_tx_hsk_ack) begin
          state_d = StUpAck;
        end else if (expire) begin
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = StUpAck;
        end
      end
      StUpAck: begin
        if (!owner_req) begin
          if (lock_q) begin
            state_d = StHold;
          end else begin
            state_d = StIdle;
            grant_d = GrantNone;
            rr_d    = ~owner_q;
          end
        end
      end
      StHold: begin
        if (owner_req) begin
          data_d  = owner_data;
          lock_d  = owner_lock;
          state_d = StTxReq;
        end else if (expire) begin
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          grant_d = GrantNone;
          rr_d    = ~owner_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = GrantNone;
        lock_d  = 1'b0;
      end
    endcase

    // Outputs are registered copies decoded from the next state.
    dreq_d = (state_d == StTxReq);
    ack0_d = (state_d == StUpAck) && !owner_d;
    ack1_d = (state_d == StUpAck) && owner_d;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      grant_q <= GrantNone;
      owner_q <= 1'b0;
      lock_q  <= 1'b0;
      rr_q    <= 1'b0;
      dreq_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      dreq_q  <= dreq_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign out_data_tx         = data_q;
  assign out_data_tx_hsk_req = dreq_q;
  assign out_req0_hsk_ack    = ack0_q;
  assign out_req1_hsk_ack    = ack1_q;
  assign out_grant           = grant_q;
  assign out_busy            = busy_q;
  assign out_timeout         = tmo_q;

endmodule

// File: tb/tb_tx_byte_arbiter.sv
// Scoreboard bench for tx_byte_arbiter: directed timing cases plus randomized framed traffic.
module tb_tx_byte_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned TC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          r0 = 1'b0, r1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic          ack0, ack1;
  logic [DW-1:0] data;
  logic          dreq, tmo, busy;
  logic [1:0]    grant;
  logic          tx_auto = 1'b0, man_ack = 1'b0, auto_ack = 1'b0;
  logic          tx_ack;
  int unsigned   tx_max_delay = 1;

  int tests = 0;
  int fails = 0;
  bit [8:0] exp_q0[$];
  bit [8:0] exp_q1[$];
  int obs_owner[$];
  int locked_owner = -1;
  int tmo_seen = 0;

  assign tx_ack = tx_auto ? auto_ack : man_ack;

  always #5 clk = ~clk;

  tx_byte_arbiter #(
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .in_clk             (clk),
    .in_rst_n           (rst_n),
    .in_req0_data       (d0),
    .in_req0_hsk_req    (r0),
    .in_req0_lock       (l0),
    .out_req0_hsk_ack   (ack0),
    .in_req1_data       (d1),
    .in_req1_hsk_req    (r1),
    .in_req1_lock       (l1),
    .out_req1_hsk_ack   (ack1),
    .out_data_tx        (data),
    .out_data_tx_hsk_req(dreq),
    .in_data_tx_hsk_ack (tx_ack),
    .out_grant          (grant),
    .out_busy           (busy),
    .out_timeout        (tmo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {grant, busy, tmo, dreq, ack0, ack1, data};
  endfunction

  function automatic logic ackv(input int idx);
    return (idx == 1) ? ack1 : ack0;
  endfunction

  task automatic set_req(input int idx, input logic v, input logic [7:0] d, input logic lk);
    if (idx == 0) begin
      r0 = v; d0 = d; l0 = lk;
    end else begin
      r1 = v; d1 = d; l1 = lk;
    end
  endtask

  task automatic start_req(input int idx, input logic [7:0] d, input logic lk);
    if (idx == 0) exp_q0.push_back({lk, d});
    else          exp_q1.push_back({lk, d});
    set_req(idx, 1'b1, d, lk);
  endtask

  task automatic finish_req(input int idx);
    int n = 0;
    while (ackv(idx) !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("req%0d ack rise", idx), ackv(idx), 1);
    if (idx == 0) r0 = 1'b0;
    else          r1 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ackv(idx) !== 1'b0 && n < 200);
    check($sformatf("req%0d ack fall", idx), ackv(idx), 0);
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic lk);
    start_req(idx, d, lk);
    finish_req(idx);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    r0 = 1'b0; r1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    man_ack = 1'b0; tx_auto = 1'b0;
    exp_q0.delete(); exp_q1.delete(); obs_owner.delete();
    @(posedge clk); #1;
    check("outputs in reset", outs(), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    locked_owner = -1;
    @(posedge clk); #1;
  endtask

  task automatic requester(input int idx);
    for (int f = 0; f < 10; f++) begin
      int unsigned len = $urandom_range(3, 1);
      for (int b = 0; b < int'(len); b++) begin
        send(idx, 8'($urandom), (b < int'(len) - 1));
        repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
      end
      repeat ($urandom_range(5, 0)) begin @(posedge clk); #1; end
    end
  endtask

  function automatic int order_bits();
    int v = 0;
    foreach (obs_owner[i]) v = (v << 1) | obs_owner[i];
    return v;
  endfunction

  // Transmitter model: acks after a random delay, drops ack once request falls.
  initial begin
    int unsigned dly;
    int n;
    forever begin
      @(posedge clk); #1;
      if (tx_auto && dreq && !auto_ack) begin
        dly = $urandom_range(tx_max_delay, 0);
        repeat (dly) begin @(posedge clk); #1; end
        auto_ack = 1'b1;
        n = 0;
        while (dreq && n < 100) begin @(posedge clk); #1; n++; end
        auto_ack = 1'b0;
      end
    end
  end

  // Monitor: each new downstream request must carry the next byte of the granted source.
  initial begin
    logic prev = 1'b0;
    bit [8:0] e;
    int own;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev = 1'b0;
        locked_owner = -1;
      end else begin
        if (tmo) begin
          tmo_seen++;
          locked_owner = -1;
        end
        if (dreq && !prev) begin
          check("grant one-hot at byte start", $onehot(grant), 1);
          own = (grant == 2'b10) ? 1 : 0;
          if (locked_owner >= 0) check("frame not interleaved", own, locked_owner);
          if (own == 0) begin
            check("scoreboard req0 nonempty", exp_q0.size() != 0, 1);
            e = (exp_q0.size() != 0) ? exp_q0.pop_front() : 9'h0;
          end else begin
            check("scoreboard req1 nonempty", exp_q1.size() != 0, 1);
            e = (exp_q1.size() != 0) ? exp_q1.pop_front() : 9'h0;
          end
          check("byte data", data, e[7:0]);
          locked_owner = e[8] ? own : -1;
          obs_owner.push_back(own);
        end
        prev = dreq;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "time limit");
  end

  initial begin
    int early;

    // Single byte, transmitter acks after 3 cycles, then pointer favours req1.
    do_reset();
    start_req(0, 8'h5A, 1'b0);
    @(posedge clk); #1;
    check("t1 dreq at T+1", dreq, 1);
    check("t1 grant", grant, 2'b01);
    check("t1 data", data, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    check("t1 dreq held", dreq, 1);
    man_ack = 1'b1;
    @(posedge clk); #1;
    check("t1 dreq low A+1", dreq, 0);
    man_ack = 1'b0;
    @(posedge clk); #1;
    check("t1 upstream ack B+1", ack0, 1);
    r0 = 1'b0;
    @(posedge clk); #1;
    check("t1 ack low and idle", {ack0, grant, busy}, 0);
    start_req(0, 8'h11, 1'b0);
    start_req(1, 8'h22, 1'b0);
    @(posedge clk); #1;
    check("t1 pointer selects req1", grant, 2'b10);
    tx_auto = 1'b1;
    fork
      finish_req(0);
      finish_req(1);
    join

    // Two simultaneous pairs from reset.
    do_reset();
    tx_auto = 1'b1; tx_max_delay = 2;
    fork
      send(0, 8'hA1, 1'b0);
      send(1, 8'hB1, 1'b0);
    join
    fork
      send(0, 8'hA2, 1'b0);
      send(1, 8'hB2, 1'b0);
    join
    check("t2 byte count", obs_owner.size(), 4);
    check("t2 owner order", order_bits(), 4'b0101);

    // Locked three-byte frame from req0 while req1 waits.
    do_reset();
    tx_auto = 1'b1;
    fork
      begin
        send(0, 8'h01, 1'b1);
        send(0, 8'h02, 1'b1);
        send(0, 8'h03, 1'b0);
      end
      send(1, 8'hAA, 1'b0);
    join
    check("t3 byte count", obs_owner.size(), 4);
    check("t3 owner order", order_bits(), 4'b0001);

    // Transmitter never acks.
    do_reset();
    start_req(0, 8'hC3, 1'b1);
    @(posedge clk); #1;
    check("t4 dreq", dreq, 1);
    early = 0;
    for (int k = 1; k < int'(TC); k++) begin
      @(posedge clk); #1;
      if (tmo || !dreq) early++;
    end
    check("t4 no early timeout", early, 0);
    @(posedge clk); #1;
    check("t4 timeout pulse", tmo, 1);
    check("t4 dreq dropped", dreq, 0);
    check("t4 requester acked", ack0, 1);
    @(posedge clk); #1;
    check("t4 pulse one cycle", tmo, 0);
    r0 = 1'b0;
    @(posedge clk); #1;
    check("t4 back to idle", {busy, grant, ack0}, 0);

    // Abandoned lock in HOLD while req0 waits.
    do_reset();
    tx_auto = 1'b1; tx_max_delay = 1;
    send(1, 8'h77, 1'b1);
    start_req(0, 8'h88, 1'b0);
    early = 0;
    for (int k = 1; k < int'(TC); k++) begin
      @(posedge clk); #1;
      if (tmo || grant != 2'b10) early++;
    end
    check("t5 hold kept owner", early, 0);
    @(posedge clk); #1;
    check("t5 timeout pulse", tmo, 1);
    check("t5 grant released", grant, 2'b00);
    @(posedge clk); #1;
    check("t5 req0 granted", grant, 2'b01);
    check("t5 pulse one cycle", tmo, 0);
    finish_req(0);

    // Reset while in TX_REQ.
    do_reset();
    start_req(1, 8'h3C, 1'b0);
    @(posedge clk); #1;
    check("t6 in tx_req", dreq, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6 outputs low in reset", outs(), 0);
    exp_q1.push_back({1'b0, 8'h3C});
    @(posedge clk); #2;
    tx_max_delay = 0; tx_auto = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6 served after reset", {dreq, grant}, 3'b110);
    finish_req(1);

    // Randomized framed traffic from both sources.
    do_reset();
    tx_auto = 1'b1; tx_max_delay = 3;
    tmo_seen = 0;
    fork
      requester(0);
      requester(1);
    join
    repeat (4) @(posedge clk);
    #1;
    check("t7 req0 queue drained", exp_q0.size(), 0);
    check("t7 req1 queue drained", exp_q1.size(), 0);
    check("t7 no timeouts", tmo_seen, 0);
    check("t7 idle at end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
